// File: rtl/video_mixer_if.sv
// Pixel, sync and fade-control bundle between the video timing/renderers and the mixer.
// The master side drives pixels, syncs and fade commands; the slave side (the mixer) returns DAC pixels and fade status.
interface video_mixer_if;
    logic [1:0] bg_r;
    logic [1:0] bg_g;
    logic [1:0] bg_b;
    logic [1:0] fg_r;
    logic [1:0] fg_g;
    logic [1:0] fg_b;
    logic       fg_opaque;
    logic       visible_in;
    logic       hsync_in;
    logic       vsync_in;
    logic       fade_out_start;
    logic       fade_in_start;

    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hsync;
    logic       vsync;
    logic [1:0] fade_level;
    logic       fade_busy;
    logic       fade_done;

    modport master (
        output bg_r, bg_g, bg_b, fg_r, fg_g, fg_b, fg_opaque, visible_in,
               hsync_in, vsync_in, fade_out_start, fade_in_start,
        input  r, g, b, hsync, vsync, fade_level, fade_busy, fade_done
    );

    modport slave (
        input  bg_r, bg_g, bg_b, fg_r, fg_g, fg_b, fg_opaque, visible_in,
               hsync_in, vsync_in, fade_out_start, fade_in_start,
        output r, g, b, hsync, vsync, fade_level, fade_busy, fade_done
    );
endinterface

// File: rtl/video_mixer.sv
// Final pixel stage: fg-over-bg composite with blanking, global fade dimming, and sync
// delay matched to the 2-cycle pixel pipeline. Fade level is stepped once per FADE_FRAMES vsyncs.
module video_mixer #(
    parameter int unsigned FADE_FRAMES      = 8,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input logic         gpu_clk,
    input logic         rst,
    video_mixer_if.slave vid
);

    localparam logic       SYNC_IDLE   = VSYNC_ACTIVE_LOW;
    localparam logic       SYNC_ACTIVE = ~VSYNC_ACTIVE_LOW;
    localparam logic [7:0] LAST_FRAME  = 8'(FADE_FRAMES - 1);
    localparam logic [1:0] LEVEL_FULL  = 2'd0;
    localparam logic [1:0] LEVEL_BLACK = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    function automatic logic [1:0] sat_sub(input logic [1:0] c, input logic [1:0] lvl);
        return (c > lvl) ? (c - lvl) : 2'd0;
    endfunction

    rgb_t       bg_px;
    rgb_t       fg_px;
    rgb_t       pix_d;
    rgb_t       pix_q;
    rgb_t       out_d;
    rgb_t       out_q;
    logic       hs1_q;
    logic       vs1_q;
    logic       hs2_q;
    logic       vs2_q;

    logic       vs_prev_q;
    logic       frame_tick;
    logic       frame_last;

    state_e     state_q;
    logic [1:0] level_q;
    logic [7:0] frame_cnt_q;
    logic       busy_q;
    logic       done_q;

    // Stage 1 composite: opacity decides, not colour, so an opaque black fg still wins.
    always_comb begin
        bg_px = {vid.bg_r, vid.bg_g, vid.bg_b};
        fg_px = {vid.fg_r, vid.fg_g, vid.fg_b};
        pix_d = vid.fg_opaque ? fg_px : bg_px;
        if (!vid.visible_in) begin
            pix_d = '0;
        end
    end

    always_comb begin
        out_d   = '0;
        out_d.r = sat_sub(pix_q.r, level_q);
        out_d.g = sat_sub(pix_q.g, level_q);
        out_d.b = sat_sub(pix_q.b, level_q);
    end

    // NOTE: rst is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge gpu_clk) begin
        if (!rst) begin
            pix_q <= '0;
            hs1_q <= SYNC_IDLE;
            vs1_q <= SYNC_IDLE;
            out_q <= '0;
            hs2_q <= SYNC_IDLE;
            vs2_q <= SYNC_IDLE;
        end else begin
            // NOTE: non-blocking updates mean stage 2 sees fade_level as it was before this edge.
            pix_q <= pix_d;
            hs1_q <= vid.hsync_in;
            vs1_q <= vid.vsync_in;
            out_q <= out_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    // Frame tick from the raw vsync; the history register idles inactive so reset never fakes an edge.
    always_ff @(posedge gpu_clk) begin
        if (!rst) begin
            vs_prev_q <= SYNC_IDLE;
        end else begin
            vs_prev_q <= vid.vsync_in;
        end
    end

    assign frame_tick = (vid.vsync_in == SYNC_ACTIVE) && (vs_prev_q == SYNC_IDLE);
    assign frame_last = (frame_cnt_q == LAST_FRAME);

    always_ff @(posedge gpu_clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            level_q     <= LEVEL_FULL;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (vid.fade_out_start) begin
                        frame_cnt_q <= '0;
                        if (level_q == LEVEL_BLACK) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= FADE_OUT;
                            busy_q  <= 1'b1;
                        end
                    end else if (vid.fade_in_start) begin
                        frame_cnt_q <= '0;
                        if (level_q == LEVEL_FULL) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= FADE_IN;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                FADE_OUT: begin
                    // fade_out_start wins a simultaneous pair, which here makes the pair a same-direction no-op.
                    if (vid.fade_in_start && !vid.fade_out_start) begin
                        state_q     <= FADE_IN;
                        frame_cnt_q <= '0;
                    end else if (frame_tick) begin
                        if (frame_last) begin
                            frame_cnt_q <= '0;
                            if (level_q >= 2'd2) begin
                                level_q <= LEVEL_BLACK;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                level_q <= level_q + 2'd1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end

                FADE_IN: begin
                    if (vid.fade_out_start) begin
                        state_q     <= FADE_OUT;
                        frame_cnt_q <= '0;
                    end else if (frame_tick) begin
                        if (frame_last) begin
                            frame_cnt_q <= '0;
                            if (level_q <= 2'd1) begin
                                level_q <= LEVEL_FULL;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                level_q <= level_q - 2'd1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vid.r          = out_q.r;
    assign vid.g          = out_q.g;
    assign vid.b          = out_q.b;
    assign vid.hsync      = hs2_q;
    assign vid.vsync      = vs2_q;
    assign vid.fade_level = level_q;
    assign vid.fade_busy  = busy_q;
    assign vid.fade_done  = done_q;

endmodule

// File: tb/tb_video_mixer.sv
// Scoreboarded bench for video_mixer: pixel/sync expectations are queued when driven and
// compared two cycles later; fade FSM status is checked inline per scenario.
module tb_video_mixer;

    logic gpu_clk = 1'b0;
    logic rst     = 1'b0;

    video_mixer_if vif ();

    video_mixer #(
        .FADE_FRAMES     (2),
        .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .gpu_clk(gpu_clk),
        .rst    (rst),
        .vid    (vif)
    );

    always #5 gpu_clk = ~gpu_clk;

    typedef struct {
        int         due;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        string      tag;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic       g_rst    = 1'b0;
    logic [5:0] g_bg     = '0;
    logic [5:0] g_fg     = '0;
    logic       g_op     = 1'b0;
    logic       g_vis    = 1'b0;
    logic       g_hs     = 1'b1;
    logic       g_vs     = 1'b1;
    logic       g_fo     = 1'b0;
    logic       g_fi     = 1'b0;
    logic       g_nopush = 1'b0;
    string      g_tag    = "reset";

    function automatic logic [1:0] sat(input logic [1:0] c, input logic [1:0] l);
        if (c > l) return c - l;
        return 2'd0;
    endfunction

    // One clock: compare due scoreboard entries, drive inputs, queue the expected output.
    task automatic cycle(input logic [1:0] lvl);
        exp_t       e;
        logic [5:0] px;
        logic [7:0] got;
        @(negedge gpu_clk);
        cyc++;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e   = sb.pop_front();
            got = {vif.r, vif.g, vif.b, vif.hsync, vif.vsync};
            checks++;
            if (e.due != cyc || got !== {e.rgb, e.hs, e.vs}) begin
                failures++;
                $display("FAIL sb_%s cyc=%0d got rgbhv=%b exp rgbhv=%b", e.tag, cyc, got, {e.rgb, e.hs, e.vs});
            end
        end
        rst                = g_rst;
        vif.bg_r           = g_bg[5:4];
        vif.bg_g           = g_bg[3:2];
        vif.bg_b           = g_bg[1:0];
        vif.fg_r           = g_fg[5:4];
        vif.fg_g           = g_fg[3:2];
        vif.fg_b           = g_fg[1:0];
        vif.fg_opaque      = g_op;
        vif.visible_in     = g_vis;
        vif.hsync_in       = g_hs;
        vif.vsync_in       = g_vs;
        vif.fade_out_start = g_fo;
        vif.fade_in_start  = g_fi;
        px = g_op ? g_fg : g_bg;
        if (!g_vis) px = '0;
        if (!g_nopush) begin
            sb.push_back('{due: cyc + 2,
                           rgb: {sat(px[5:4], lvl), sat(px[3:2], lvl), sat(px[1:0], lvl)},
                           hs: g_hs, vs: g_vs, tag: g_tag});
        end
    endtask

    // One frame: vsync active for one cycle, then two idle cycles; lvl is the level after this edge.
    task automatic frame(input logic [1:0] lvl, input logic exp_done, input logic exp_busy, input string nm);
        g_vs = 1'b0;
        cycle(lvl);
        g_vs = 1'b1;
        cycle(lvl);
        checks++;
        if (vif.fade_level !== lvl) begin
            failures++;
            $display("FAIL %s_level got=%0d exp=%0d", nm, vif.fade_level, lvl);
        end
        checks++;
        if (vif.fade_done !== exp_done) begin
            failures++;
            $display("FAIL %s_done got=%b exp=%b", nm, vif.fade_done, exp_done);
        end
        checks++;
        if (vif.fade_busy !== exp_busy) begin
            failures++;
            $display("FAIL %s_busy got=%b exp=%b", nm, vif.fade_busy, exp_busy);
        end
        cycle(lvl);
        checks++;
        if (vif.fade_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_width got=%b exp=0", nm, vif.fade_done);
        end
    endtask

    task automatic pulse_start(input logic fo, input logic fi, input logic [1:0] lvl,
                               input logic exp_busy, input logic exp_done, input string nm);
        g_fo = fo;
        g_fi = fi;
        cycle(lvl);
        g_fo = 1'b0;
        g_fi = 1'b0;
        cycle(lvl);
        checks++;
        if (vif.fade_busy !== exp_busy || vif.fade_done !== exp_done || vif.fade_level !== lvl) begin
            failures++;
            $display("FAIL %s got busy=%b done=%b level=%0d exp busy=%b done=%b level=%0d",
                     nm, vif.fade_busy, vif.fade_done, vif.fade_level, exp_busy, exp_done, lvl);
        end
    endtask

    task automatic test_reset();
        g_tag = "reset";
        g_rst = 1'b0;
        repeat (3) cycle(2'd0);
        checks++;
        if ({vif.r, vif.g, vif.b, vif.hsync, vif.vsync} !== 8'b000000_11) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000011", {vif.r, vif.g, vif.b, vif.hsync, vif.vsync});
        end
        checks++;
        if (vif.fade_level !== 2'd0 || vif.fade_busy !== 1'b0 || vif.fade_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_fade got level=%0d busy=%b done=%b exp 0/0/0",
                     vif.fade_level, vif.fade_busy, vif.fade_done);
        end
        g_rst = 1'b1;
        repeat (2) cycle(2'd0);
    endtask

    task automatic test_pixel_mux();
        g_tag = "mux";
        g_bg  = 6'b11_00_00;
        g_fg  = 6'b00_11_00;
        g_vis = 1'b1;
        for (int i = 0; i < 8; i++) begin
            g_op = i[0];
            g_hs = (i % 3 == 0) ? 1'b0 : 1'b1;
            cycle(2'd0);
        end
        g_tag = "mux_opaque_black";
        g_bg  = 6'b11_11_11;
        g_fg  = 6'b00_00_00;
        g_op  = 1'b1;
        cycle(2'd0);
        g_tag = "mux_rand";
        for (int i = 0; i < 8; i++) begin
            g_bg = 6'($urandom);
            g_fg = 6'($urandom);
            g_op = 1'($urandom);
            g_hs = 1'($urandom);
            cycle(2'd0);
        end
        g_hs = 1'b1;
    endtask

    task automatic test_blank_sync();
        g_tag = "blank";
        g_vis = 1'b0;
        g_op  = 1'b1;
        g_fg  = 6'b11_11_11;
        for (int i = 0; i < 10; i++) begin
            g_bg = 6'($urandom);
            g_hs = 1'($urandom);
            g_vs = 1'($urandom);
            cycle(2'd0);
        end
        g_hs  = 1'b1;
        g_vs  = 1'b1;
        g_vis = 1'b1;
        g_op  = 1'b0;
        g_bg  = 6'b11_10_01;
        cycle(2'd0);
    endtask

    task automatic test_fade_out();
        g_tag = "fade_out";
        pulse_start(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "fo_start");
        frame(2'd0, 1'b0, 1'b1, "fo_e1");
        frame(2'd1, 1'b0, 1'b1, "fo_e2");
        frame(2'd1, 1'b0, 1'b1, "fo_e3");
        frame(2'd2, 1'b0, 1'b1, "fo_e4");
        frame(2'd2, 1'b0, 1'b1, "fo_e5");
        frame(2'd3, 1'b1, 1'b0, "fo_e6");
        frame(2'd3, 1'b0, 1'b0, "fo_hold");
    endtask

    task automatic test_start_at_limit();
        g_tag = "limit";
        pulse_start(1'b1, 1'b0, 2'd3, 1'b0, 1'b1, "fo_at_black");
        cycle(2'd3);
        checks++;
        if (vif.fade_done !== 1'b0) begin
            failures++;
            $display("FAIL fo_at_black_width got=%b exp=0", vif.fade_done);
        end
    endtask

    task automatic test_fade_in();
        g_tag = "fade_in";
        pulse_start(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, "fi_start");
        frame(2'd3, 1'b0, 1'b1, "fi_e1");
        frame(2'd2, 1'b0, 1'b1, "fi_e2");
        frame(2'd2, 1'b0, 1'b1, "fi_e3");
        frame(2'd1, 1'b0, 1'b1, "fi_e4");
        frame(2'd1, 1'b0, 1'b1, "fi_e5");
        frame(2'd0, 1'b1, 1'b0, "fi_e6");
    endtask

    task automatic test_reverse();
        g_tag = "reverse";
        pulse_start(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, "rev_out_start");
        frame(2'd0, 1'b0, 1'b1, "rev_o1");
        frame(2'd1, 1'b0, 1'b1, "rev_o2");
        frame(2'd1, 1'b0, 1'b1, "rev_o3");
        frame(2'd2, 1'b0, 1'b1, "rev_o4");
        frame(2'd2, 1'b0, 1'b1, "rev_o5");
        pulse_start(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, "rev_turn");
        frame(2'd2, 1'b0, 1'b1, "rev_i1");
        pulse_start(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, "rev_same_dir");
        frame(2'd1, 1'b0, 1'b1, "rev_i2");
        frame(2'd1, 1'b0, 1'b1, "rev_i3");
        frame(2'd0, 1'b1, 1'b0, "rev_i4");
    endtask

    task automatic test_both_starts();
        g_tag = "both";
        pulse_start(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, "both_start");
        frame(2'd0, 1'b0, 1'b1, "both_e1");
        frame(2'd1, 1'b0, 1'b1, "both_e2");
        frame(2'd1, 1'b0, 1'b1, "both_e3");
        frame(2'd2, 1'b0, 1'b1, "both_e4");
    endtask

    task automatic test_reset_mid_fade();
        g_tag    = "mid_reset";
        g_nopush = 1'b1;
        g_hs     = 1'b0;
        repeat (2) cycle(2'd2);
        g_rst = 1'b0;
        cycle(2'd2);
        g_rst = 1'b1;
        g_hs  = 1'b1;
        g_vis = 1'b0;
        cycle(2'd0);
        checks++;
        if ({vif.r, vif.g, vif.b, vif.hsync, vif.vsync} !== 8'b000000_11) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b exp=00000011", {vif.r, vif.g, vif.b, vif.hsync, vif.vsync});
        end
        checks++;
        if (vif.fade_level !== 2'd0 || vif.fade_busy !== 1'b0 || vif.fade_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_fade got level=%0d busy=%b done=%b exp 0/0/0",
                     vif.fade_level, vif.fade_busy, vif.fade_done);
        end
        cycle(2'd0);
        checks++;
        if (vif.fade_done !== 1'b0 || vif.fade_level !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_no_done got done=%b level=%0d exp 0/0", vif.fade_done, vif.fade_level);
        end
        g_nopush = 1'b0;
        g_vis    = 1'b1;
        cycle(2'd0);
    endtask

    task automatic test_fade_in_at_full();
        g_tag = "fi_at_full";
        pulse_start(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "fi_at_full");
        cycle(2'd0);
        checks++;
        if (vif.fade_done !== 1'b0 || vif.fade_busy !== 1'b0) begin
            failures++;
            $display("FAIL fi_at_full_after got done=%b busy=%b exp 0/0", vif.fade_done, vif.fade_busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_pixel_mux();
        test_blank_sync();
        test_fade_out();
        test_start_at_limit();
        test_fade_in();
        test_reverse();
        test_both_starts();
        test_reset_mid_fade();
        test_fade_in_at_full();
        g_tag = "drain";
        repeat (3) cycle(2'd0);
        g_nopush = 1'b1;
        repeat (3) cycle(2'd0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
